// File: rtl/psum_requant_drain_if.sv
// Valid/ready word stream with a row/tile "last" marker travelling alongside the data.
interface psum_requant_drain_if #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/psum_requant_drain.sv
// Requantises sign-magnitude accumulator words to operand format (round, saturate, optional ReLU)
// and buffers the results in a show-ahead FIFO.
module psum_requant_drain #(
    parameter int DEC_PART  = 3,
    parameter int MANT_PART = 12,
    parameter int FLAG      = 1,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16,
    localparam int ACC_W    = 2*DEC_PART + 2*MANT_PART + FLAG + 1,
    localparam int OUT_W    = DEC_PART + MANT_PART + 1,
    localparam int LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   relu_en,
    input  logic                   clear_stats,
    psum_requant_drain_if.slave    in_bus,
    psum_requant_drain_if.master   out_bus,
    output logic [CNT_W-1:0]       sat_count,
    output logic [LVL_W-1:0]       fifo_level
);

    localparam int AW   = $clog2(DEPTH);
    localparam int RM_W = ACC_W - MANT_PART;
    localparam logic [RM_W-1:0] MAXMAG = RM_W'((1 << (OUT_W-1)) - 1);

    logic            s1_valid;
    logic            s1_sign;
    logic            s1_last;
    logic [RM_W-1:0] s1_rmag;
    logic            accept;
    logic [LVL_W:0]  occ;

    // Credit counts the word sitting in S1 so it always has a FIFO slot on the next edge.
    assign occ          = {1'b0, fifo_level} + {{LVL_W{1'b0}}, s1_valid};
    assign in_bus.ready = occ < (LVL_W+1)'(DEPTH);
    assign accept       = in_bus.valid & in_bus.ready;

    always_ff @(posedge clock) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_last  <= 1'b0;
            s1_rmag  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sign <= in_bus.data[ACC_W-1];
                s1_last <= in_bus.last;
                s1_rmag <= {1'b0, in_bus.data[ACC_W-2:MANT_PART]}
                           + RM_W'(in_bus.data[MANT_PART-1]);
            end
        end
    end

    logic             sat;
    logic [OUT_W-2:0] wmag;
    logic [OUT_W-1:0] wdata;

    always_comb begin
        sat   = s1_rmag > MAXMAG;
        wmag  = sat ? MAXMAG[OUT_W-2:0] : s1_rmag[OUT_W-2:0];
        wdata = {s1_sign && (wmag != '0), wmag};
        if (relu_en && wdata[OUT_W-1]) begin
            wdata = '0;
        end
    end

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign push = s1_valid;
    assign pop  = out_bus.valid & out_bus.ready;

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= wdata;
            mem_last[wr_ptr] <= s1_last;
        end
    end

    assign out_bus.valid = fifo_level != '0;
    assign out_bus.data  = out_bus.valid ? mem_data[rd_ptr] : '0;
    assign out_bus.last  = out_bus.valid ? mem_last[rd_ptr] : 1'b0;

    always_ff @(posedge clock) begin
        if (rst || clear_stats) begin
            sat_count <= '0;
        end else if (push && sat && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_psum_requant_drain.sv
// Directed-vector bench for psum_requant_drain: rounding, saturation, ReLU, backpressure and reset.
module tb_psum_requant_drain;

    logic        clock = 1'b0;
    logic        rst;
    logic        relu_en;
    logic        clear_stats;
    logic [15:0] sat_count;
    logic [2:0]  fifo_level;
    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clock = ~clock;

    psum_requant_drain_if #(.W(32)) in_bus ();
    psum_requant_drain_if #(.W(16)) out_bus ();

    psum_requant_drain #(
        .DEC_PART (3),
        .MANT_PART(12),
        .FLAG     (1),
        .DEPTH    (4),
        .CNT_W    (16)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .relu_en    (relu_en),
        .clear_stats(clear_stats),
        .in_bus     (in_bus),
        .out_bus    (out_bus),
        .sat_count  (sat_count),
        .fifo_level (fifo_level)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        in_bus.valid = 1'b0;
        in_bus.data  = '0;
        in_bus.last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++; if (in_bus.ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_bus.ready); else n_pass++;
        n_total++; if (out_bus.valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_bus.valid); else n_pass++;
        n_total++; if (out_bus.data !== 16'h0000) $display("FAIL reset_out_data got %h exp 0000", out_bus.data); else n_pass++;
        n_total++; if (out_bus.last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_bus.last); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d exp 0", fifo_level); else n_pass++;
        n_total++; if (sat_count !== 16'd0) $display("FAIL reset_sat_count got %0d exp 0", sat_count); else n_pass++;
    endtask

    task automatic test_rounding();
        logic [31:0] acc_v  [4] = '{32'h0180_0000, 32'h0000_0800, 32'h8000_07FF, 32'h8000_1800};
        logic        last_v [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] exp_v  [4] = '{16'h1800, 16'h0001, 16'h0000, 16'h8002};
        out_bus.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = acc_v[i];
            in_bus.last  = last_v[i];
            tick();
            drive_idle();
            n_total++; if (out_bus.valid !== 1'b0) $display("FAIL round_latency[%0d] out_valid got %b exp 0", i, out_bus.valid); else n_pass++;
            tick();
            n_total++; if (out_bus.valid !== 1'b1) $display("FAIL round_valid[%0d] got %b exp 1", i, out_bus.valid); else n_pass++;
            n_total++; if (out_bus.data !== exp_v[i]) $display("FAIL round_data[%0d] got %h exp %h", i, out_bus.data, exp_v[i]); else n_pass++;
            n_total++; if (out_bus.last !== last_v[i]) $display("FAIL round_last[%0d] got %b exp %b", i, out_bus.last, last_v[i]); else n_pass++;
            tick();
        end
        n_total++; if (out_bus.valid !== 1'b0) $display("FAIL round_drained out_valid got %b exp 0", out_bus.valid); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [31:0] acc_v  [6] = '{32'h0800_0000, 32'h8800_0000, 32'h8800_0000,
                                    32'h8000_1800, 32'h07FF_F000, 32'h07FF_F800};
        logic        relu_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [15:0] exp_v  [6] = '{16'h7FFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
        logic [15:0] cnt_v  [6] = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd4};
        out_bus.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            relu_en      = relu_v[i];
            in_bus.valid = 1'b1;
            in_bus.data  = acc_v[i];
            in_bus.last  = 1'b0;
            tick();
            drive_idle();
            tick();
            relu_en = 1'b0;
            n_total++; if (out_bus.data !== exp_v[i]) $display("FAIL sat_data[%0d] got %h exp %h", i, out_bus.data, exp_v[i]); else n_pass++;
            n_total++; if (sat_count !== cnt_v[i]) $display("FAIL sat_count[%0d] got %0d exp %0d", i, sat_count, cnt_v[i]); else n_pass++;
            tick();
        end
        // Clear coinciding with a saturation event must win.
        in_bus.valid = 1'b1;
        in_bus.data  = 32'h0800_0000;
        tick();
        drive_idle();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        n_total++; if (sat_count !== 16'd0) $display("FAIL sat_clear_same_cycle got %0d exp 0", sat_count); else n_pass++;
        n_total++; if (out_bus.data !== 16'h7FFF) $display("FAIL sat_clear_data got %h exp 7fff", out_bus.data); else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        int unsigned idx = 0;
        int unsigned got = 0;
        logic        acc;
        out_bus.ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = 32'(idx + 1) << 12;
            in_bus.last  = (idx == 3);
            acc = in_bus.ready;
            tick();
            if (acc) idx++;
        end
        drive_idle();
        n_total++; if (idx !== 4) $display("FAIL bp_accepted got %0d exp 4", idx); else n_pass++;
        n_total++; if (in_bus.ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", in_bus.ready); else n_pass++;
        n_total++; if (fifo_level !== 3'd4) $display("FAIL bp_level got %0d exp 4", fifo_level); else n_pass++;
        out_bus.ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_bus.valid && got < 4) begin
                n_total++; if (out_bus.data !== 16'(got + 1)) $display("FAIL bp_data[%0d] got %h exp %h", got, out_bus.data, 16'(got + 1)); else n_pass++;
                n_total++; if (out_bus.last !== (got == 3)) $display("FAIL bp_last[%0d] got %b exp %b", got, out_bus.last, (got == 3)); else n_pass++;
                got++;
            end
            tick();
        end
        n_total++; if (got !== 4) $display("FAIL bp_drained got %0d exp 4", got); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL bp_level_after got %0d exp 0", fifo_level); else n_pass++;
        n_total++; if (in_bus.ready !== 1'b1) $display("FAIL bp_in_ready_after got %b exp 1", in_bus.ready); else n_pass++;
    endtask

    task automatic test_toggle();
        logic [31:0] acc_v [6];
        logic [15:0] exp_v [6];
        logic [15:0] rx    [6];
        logic        rx_last [6];
        int unsigned idx = 0;
        int unsigned got = 0;
        int unsigned max_lvl = 0;
        logic        acc;
        for (int j = 0; j < 6; j++) begin
            acc_v[j] = (j % 2 == 0) ? (32'(j + 1) << 12) : (32'h8000_0000 | (32'(j + 1) << 12));
            exp_v[j] = (j % 2 == 0) ? 16'(j + 1) : (16'h8000 | 16'(j + 1));
            rx[j] = 'x;
            rx_last[j] = 1'bx;
        end
        for (int c = 0; c < 60; c++) begin
            in_bus.valid  = (idx < 6);
            in_bus.data   = (idx < 6) ? acc_v[idx] : '0;
            in_bus.last   = (idx == 5);
            out_bus.ready = (c % 2 == 0);
            acc = in_bus.valid & in_bus.ready;
            if (out_bus.valid && out_bus.ready && got < 6) begin
                rx[got]      = out_bus.data;
                rx_last[got] = out_bus.last;
                got++;
            end
            if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
            tick();
            if (acc) idx++;
            if (got == 6) break;
        end
        drive_idle();
        out_bus.ready = 1'b0;
        n_total++; if (got !== 6) $display("FAIL toggle_count got %0d exp 6", got); else n_pass++;
        n_total++; if (max_lvl > 4) $display("FAIL toggle_max_level got %0d exp <=4", max_lvl); else n_pass++;
        for (int j = 0; j < 6; j++) begin
            n_total++; if (rx[j] !== exp_v[j]) $display("FAIL toggle_data[%0d] got %h exp %h", j, rx[j], exp_v[j]); else n_pass++;
        end
        n_total++; if (rx_last[5] !== 1'b1) $display("FAIL toggle_last got %b exp 1", rx_last[5]); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] acc_v [4] = '{32'h0800_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000};
        out_bus.ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_bus.valid = 1'b1;
            in_bus.data  = acc_v[c];
            tick();
        end
        drive_idle();
        n_total++; if (fifo_level !== 3'd3) $display("FAIL mid_pre_level got %0d exp 3", fifo_level); else n_pass++;
        n_total++; if (sat_count !== 16'd1) $display("FAIL mid_pre_sat got %0d exp 1", sat_count); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (out_bus.valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", out_bus.valid); else n_pass++;
        n_total++; if (fifo_level !== 3'd0) $display("FAIL mid_level got %0d exp 0", fifo_level); else n_pass++;
        n_total++; if (in_bus.ready !== 1'b1) $display("FAIL mid_in_ready got %b exp 1", in_bus.ready); else n_pass++;
        n_total++; if (sat_count !== 16'd0) $display("FAIL mid_sat got %0d exp 0", sat_count); else n_pass++;
        n_total++; if (out_bus.data !== 16'h0000) $display("FAIL mid_out_data got %h exp 0000", out_bus.data); else n_pass++;
        tick();
        n_total++; if (out_bus.valid !== 1'b0) $display("FAIL mid_s1_flushed got %b exp 0", out_bus.valid); else n_pass++;
        out_bus.ready = 1'b1;
        in_bus.valid  = 1'b1;
        in_bus.data   = 32'h0000_0800;
        tick();
        drive_idle();
        tick();
        n_total++; if (out_bus.valid !== 1'b1) $display("FAIL mid_post_valid got %b exp 1", out_bus.valid); else n_pass++;
        n_total++; if (out_bus.data !== 16'h0001) $display("FAIL mid_post_data got %h exp 0001", out_bus.data); else n_pass++;
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        relu_en       = 1'b0;
        clear_stats   = 1'b0;
        out_bus.ready = 1'b0;
        drive_idle();
        test_reset();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_toggle();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
